// File: rtl/regfile_sb_pkg.sv
// Shared core definitions for the register file slice: machine word width,
// the default architectural register count and the matching scalar types.
package regfile_sb_pkg;

  localparam int XLEN      = 32;
  localparam int CORE_NREG = 32;
  localparam int CORE_AW   = $clog2(CORE_NREG);

  typedef logic [XLEN-1:0]    data_t;
  typedef logic [CORE_AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by an accepted issue and
// cleared by any write to that register; a same-edge set beats a clear.
module reg_scoreboard #(
  parameter  int NREG = 32,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  input  logic [NWR-1:0]         clr_en,
  input  logic [NWR-1:0][AW-1:0] clr_addr,
  output logic [NREG-1:0]        busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // NOTE: every combinational output gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NWR; i++) begin
      if (clr_en[i]) w_busy_nxt[clr_addr[i]] = 1'b0;
    end
    if (set_en) w_busy_nxt[set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with optional write-to-read bypass and a
// busy-bit scoreboard that stalls re-issue of a destination with a pending write.
module regfile_sb #(
  parameter  int XLEN   = regfile_sb_pkg::XLEN,
  parameter  int NREG   = regfile_sb_pkg::CORE_NREG,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_ready,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd,
  output logic                     issue_ready,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_busy;
  logic [NWR-1:0]  w_clr_en;
  logic            w_set_en;
  logic            w_wr_hit_issue;

  // NOTE: the storage array is cleared by the async reset on purpose -- reset
  // must zero architectural state immediately, so it cannot map to a plain RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else begin
      // Ascending port order: the highest-index port's assignment lands last.
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && wr_addr[i] != '0) r_regs[wr_addr[i]] <= wr_data[i];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_data[k]  = r_regs[rd_addr[k]];
      rd_ready[k] = ~w_busy[rd_addr[k]];
      if (BYPASS != 0 && rd_addr[k] != '0) begin
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && wr_addr[i] == rd_addr[k]) begin
            rd_data[k]  = wr_data[i];
            rd_ready[k] = 1'b1;
          end
        end
      end
      if (rst) begin
        rd_data[k]  = '0;
        rd_ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_wr_hit_issue = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && wr_addr[i] == issue_rd) w_wr_hit_issue = 1'b1;
      w_clr_en[i] = wr_en[i] && (wr_addr[i] != '0);
    end
  end

  // A write landing this cycle resolves the WAW hazard, so the issue may proceed.
  assign issue_ready = rst | ~(w_busy[issue_rd] & ~w_wr_hit_issue);
  assign w_set_en    = issue_valid & issue_ready & (issue_rd != '0) & ~rst;

  reg_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (w_set_en),
    .set_addr (issue_rd),
    .clr_en   (w_clr_en),
    .clr_addr (wr_addr),
    .busy     (w_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus
// and are compared every cycle against an array model of registers and busy bits.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data_a, rd_data_b;
  logic [NRD-1:0]           rd_ready_a, rd_ready_b;
  logic                     issue_valid;
  logic [AW-1:0]            issue_rd;
  logic                     issue_ready_a, issue_ready_b;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;

  int n_checks = 0;
  int n_pass   = 0;
  bit run      = 1'b0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_ready(rd_ready_a),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Reference model: register contents and pending-write flags.
  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_busy [NREG];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit write_hits(input logic [AW-1:0] a);
    for (int i = 0; i < NWR; i++) if (wr_en[i] && wr_addr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input bit byp, input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    if (rst || a == 0) return '0;
    d = m_mem[a];
    if (byp) for (int i = 0; i < NWR; i++) if (wr_en[i] && wr_addr[i] == a) d = wr_data[i];
    return d;
  endfunction

  function automatic bit exp_ready(input bit byp, input logic [AW-1:0] a);
    if (rst || a == 0) return 1'b1;
    if (byp && write_hits(a)) return 1'b1;
    return !m_busy[a];
  endfunction

  function automatic bit exp_issue_ready();
    if (rst || issue_rd == 0) return 1'b1;
    if (write_hits(issue_rd)) return 1'b1;
    return !m_busy[issue_rd];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[r]  <= '0;
        m_busy[r] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && wr_addr[i] != 0) begin
          m_mem[wr_addr[i]]  <= wr_data[i];
          m_busy[wr_addr[i]] <= 1'b0;
        end
      end
      if (issue_valid && exp_issue_ready() && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("cyc_a_data%0d", k),  rd_data_a[k],  exp_data(1'b1, rd_addr[k]));
        check($sformatf("cyc_a_ready%0d", k), rd_ready_a[k], exp_ready(1'b1, rd_addr[k]));
        check($sformatf("cyc_b_data%0d", k),  rd_data_b[k],  exp_data(1'b0, rd_addr[k]));
        check($sformatf("cyc_b_ready%0d", k), rd_ready_b[k], exp_ready(1'b0, rd_addr[k]));
      end
      check("cyc_a_issue_ready", issue_ready_a, exp_issue_ready());
      check("cyc_b_issue_ready", issue_ready_b, exp_issue_ready());
    end
  end

  task automatic idle();
    rd_addr     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    run = 1'b1;
    #1;
    check("rst_issue_ready", issue_ready_a, 1);
    check("rst_ready", rd_ready_a, 2'b11);
    tick();
    tick();
    rst = 1'b0;

    // Async reset wipes a freshly written register before the next edge.
    wr_en[0] = 1'b1; wr_addr[0] = 5; wr_data[0] = 32'hDEADBEEF;
    tick();
    idle();
    rd_addr[0] = 5;
    #1 check("r5_written", rd_data_a[0], 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1 check("r5_after_async_rst", rd_data_a[0], 0);
    check("model_r5_rst", m_mem[5], 0);
    tick();
    rst = 1'b0;

    // Same-cycle bypass versus registered read.
    wr_en[0] = 1'b1; wr_addr[0] = 3; wr_data[0] = 32'h1234; rd_addr[0] = 3;
    #1 check("byp_a_data", rd_data_a[0], 32'h1234);
    check("byp_a_ready", rd_ready_a[0], 1);
    check("nobyp_b_old", rd_data_b[0], 0);
    tick();
    idle(); rd_addr[0] = 3;
    #1 check("nobyp_b_next", rd_data_b[0], 32'h1234);

    // Write port conflict: highest index wins.
    wr_en = 2'b11; wr_addr[0] = 7; wr_addr[1] = 7; wr_data[0] = 32'h1; wr_data[1] = 32'h2;
    rd_addr[1] = 7;
    #1 check("conflict_byp", rd_data_a[1], 2);
    tick();
    idle(); rd_addr[1] = 7;
    #1 check("conflict_a", rd_data_a[1], 2);
    check("conflict_b", rd_data_b[1], 2);
    check("model_r7", m_mem[7], 2);

    // Scoreboard: issue, WAW stall, clear by write, reissue.
    issue_valid = 1'b1; issue_rd = 9;
    #1 check("issue9_first", issue_ready_a, 1);
    tick();
    idle(); rd_addr[0] = 9; issue_valid = 1'b1; issue_rd = 9;
    #1 check("r9_busy_ready", rd_ready_a[0], 0);
    check("issue9_stall", issue_ready_a, 0);
    check("model_r9_busy", m_busy[9], 1);
    tick();
    idle(); rd_addr[0] = 9; wr_en[0] = 1'b1; wr_addr[0] = 9; wr_data[0] = 32'h55;
    #1 check("r9_wr_byp_ready", rd_ready_a[0], 1);
    check("r9_wr_nobyp_ready", rd_ready_b[0], 0);
    tick();
    idle(); rd_addr[0] = 9; issue_valid = 1'b1; issue_rd = 9;
    #1 check("r9_cleared_ready", rd_ready_b[0], 1);
    check("r9_data", rd_data_b[0], 32'h55);
    check("issue9_again", issue_ready_a, 1);
    tick();

    // Set/clear collision on r4: set wins, data updates.
    idle(); issue_valid = 1'b1; issue_rd = 4;
    tick();
    idle(); issue_valid = 1'b1; issue_rd = 4; wr_en[1] = 1'b1; wr_addr[1] = 4; wr_data[1] = 32'hABCD;
    #1 check("collide_issue_ready", issue_ready_a, 1);
    tick();
    idle(); rd_addr[0] = 4;
    #1 check("collide_busy", rd_ready_b[0], 0);
    check("collide_data", rd_data_b[0], 32'hABCD);
    check("model_r4_busy", m_busy[4], 1);

    // Register zero.
    idle(); issue_valid = 1'b1; issue_rd = 0; wr_en[0] = 1'b1; wr_addr[0] = 0; wr_data[0] = 32'hFFFF;
    #1 check("x0_issue_ready", issue_ready_a, 1);
    check("x0_data", rd_data_a[0], 0);
    check("x0_ready", rd_ready_a[0], 1);
    tick();
    idle();
    #1 check("x0_after", rd_data_b[0], 0);

    // Randomized traffic over a narrow register window to force collisions.
    for (int n = 0; n < 500; n++) begin
      tick();
      rst         = ($urandom_range(0, 63) == 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      wr_en       = 2'($urandom_range(0, 3));
      for (int i = 0; i < NWR; i++) begin
        wr_addr[i] = 5'($urandom_range(0, 7));
        wr_data[i] = $urandom;
      end
      for (int k = 0; k < NRD; k++) rd_addr[k] = 5'($urandom_range(0, 7));
    end
    tick();
    rst = 1'b0;
    idle();
    tick();
    run = 1'b0;
    #1 $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
